// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, registered memory address/data/length,
// combinational write strobe, big-endian read extraction and a valid/ready response port.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 5096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wr_data,
    output logic [2:0]  mem_write_length,
    output logic        mem_wr_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        write_reg;
    logic [2:0]  funct3_reg;
    logic        err_reg;
    logic [31:0] mem_address_reg;
    logic [31:0] mem_wr_data_reg;
    logic [2:0]  mem_write_length_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_error_reg;

    logic [32:0] req_size;
    logic        funct3_illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_error;
    logic [31:0] req_wdata_aligned;
    logic [31:0] load_value;
    logic        accept;

    assign accept = (state_reg == IDLE) && req_valid;

    // Request decode; size 4 is used for funct3[1:0]=3, which is always illegal anyway.
    always_comb begin
        req_size = 33'd4;
        case (req_funct3[1:0])
            2'b00:   req_size = 33'd1;
            2'b01:   req_size = 33'd2;
            default: req_size = 33'd4;
        endcase
    end

    always_comb begin
        funct3_illegal = 1'b0;
        if (req_write) begin
            funct3_illegal = (req_funct3 > 3'b010);
        end else begin
            funct3_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                             (req_funct3 == 3'b111);
        end
    end

    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign out_of_range = ({1'b0, req_addr} + req_size) > 33'(MEM_BYTES);

    assign req_error = funct3_illegal || misaligned || out_of_range;

    always_comb begin
        req_wdata_aligned = req_wdata;
        case (req_funct3[1:0])
            2'b00:   req_wdata_aligned = {req_wdata[7:0], 24'h0};
            2'b01:   req_wdata_aligned = {req_wdata[15:0], 16'h0};
            default: req_wdata_aligned = req_wdata;
        endcase
    end

    // The memory returns the addressed byte in the top lane.
    always_comb begin
        load_value = 32'h0;
        case (funct3_reg)
            3'b000:  load_value = {{24{mem_read_data[31]}}, mem_read_data[31:24]};
            3'b100:  load_value = {24'h0, mem_read_data[31:24]};
            3'b001:  load_value = {{16{mem_read_data[31]}}, mem_read_data[31:16]};
            3'b101:  load_value = {16'h0, mem_read_data[31:16]};
            3'b010:  load_value = mem_read_data;
            default: load_value = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write strobe decodes only registered state, so it is glitch-free and drops with reset.
    always_comb begin
        req_ready     = (state_reg == IDLE);
        resp_valid    = (state_reg == RESP);
        mem_wr_enable = (state_reg == ACCESS) && write_reg && !err_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_reg            <= 1'b0;
            funct3_reg           <= 3'b000;
            err_reg              <= 1'b0;
            mem_address_reg      <= 32'h0;
            mem_wr_data_reg      <= 32'h0;
            mem_write_length_reg <= 3'b000;
            resp_rdata_reg       <= 32'h0;
            resp_error_reg       <= 1'b0;
        end else begin
            if (accept) begin
                write_reg            <= req_write;
                funct3_reg           <= req_funct3;
                err_reg              <= req_error;
                mem_address_reg      <= req_addr;
                mem_wr_data_reg      <= req_wdata_aligned;
                mem_write_length_reg <= {1'b0, req_funct3[1:0]};
            end
            if (state_reg == ACCESS) begin
                resp_error_reg <= err_reg;
                resp_rdata_reg <= (write_reg || err_reg) ? 32'h0 : load_value;
            end
        end
    end

    assign mem_address      = mem_address_reg;
    assign mem_wr_data      = mem_wr_data_reg;
    assign mem_write_length = mem_write_length_reg;
    assign resp_rdata       = resp_rdata_reg;
    assign resp_error       = resp_error_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, directed and randomized requests
// checked against an arithmetic model of RV32I load/store rules.
module tb_load_store_unit;

    localparam int MEM_BYTES = 5096;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_wr_data;
    logic [2:0]  mem_write_length;
    logic        mem_wr_enable;
    logic [31:0] mem_read_data;

    logic [7:0]  dmem    [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        load_pattern;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_wr_data      (mem_wr_data),
        .mem_write_length (mem_write_length),
        .mem_wr_enable    (mem_wr_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pattern_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Data memory: big-endian, left-justified write data, combinational read.
    always @(posedge clk) begin
        if (load_pattern) begin
            for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= pattern_byte(i);
        end else if (mem_wr_enable) begin
            for (int i = 0; i < 4; i++) begin
                if ((i < (1 << mem_write_length)) &&
                    (longint'(mem_address) + i < MEM_BYTES))
                    dmem[13'(mem_address + 32'(i))] <= mem_wr_data[31 - 8*i -: 8];
            end
        end
    end

    always_comb begin
        mem_read_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (longint'(mem_address) + i < MEM_BYTES)
                mem_read_data[31 - 8*i -: 8] = dmem[13'(mem_address + 32'(i))];
        end
    end

    // ---------------- reference model ----------------
    function automatic int access_size(input logic [2:0] f3);
        int sz;
        sz = 1 << f3[1:0];
        if (sz > 4) sz = 4;
        return sz;
    endfunction

    function automatic logic model_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
        int     sz;
        logic   illegal;
        longint last;
        sz      = access_size(f3);
        illegal = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        last    = longint'(a) + sz;
        return illegal || ((longint'(a) % sz) != 0) || (last > MEM_BYTES);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        longint b [4];
        for (int i = 0; i < 4; i++)
            b[i] = (longint'(a) + i < MEM_BYTES) ? longint'(ref_mem[int'(a) + i]) : 0;
        case (f3)
            3'd0:    v = (b[0] >= 128) ? b[0] - 256 : b[0];
            3'd4:    v = b[0];
            3'd1:    begin v = b[0] * 256 + b[1]; if (v >= 32768) v = v - 65536; end
            3'd5:    v = b[0] * 256 + b[1];
            3'd2:    v = ((b[0] * 256 + b[1]) * 256 + b[2]) * 256 + b[3];
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = access_size(f3);
        for (int i = 0; i < n; i++)
            ref_mem[int'(a) + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    function automatic int count_diffs();
        int d;
        d = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (dmem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    // Drives one request and reports what was observed: latency to resp_valid,
    // write-strobe cycles, and protocol violations (ready/valid/stability).
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int stall,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int wes, output int viol);
        int n;
        lat = 0; wes = 0; viol = 0; rd = 32'hx; er = 1'bx;
        @(negedge clk);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        resp_ready = (stall == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_wr_enable === 1'b1) wes++;
            if (resp_valid === 1'b1) begin lat = k; break; end
            if (req_ready !== 1'b0) viol++;
        end
        if (lat != 0) begin
            rd = resp_rdata; er = resp_error;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_error !== er ||
                    req_ready !== 1'b0 || mem_wr_enable !== 1'b0) viol++;
            end
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) viol++;
        end
        $display("txn w=%0d f3=%0d addr=%h wdata=%h stall=%0d -> rdata=%h err=%b lat=%0d we=%0d viol=%0d",
                 w, f3, a, wd, stall, rd, er, lat, wes, viol);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [103:0] obs;
        logic [103:0] expv;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1; load_pattern = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = pattern_byte(i);
        repeat (3) @(posedge clk);
        #1 load_pattern = 1'b0;
        @(negedge clk);
        obs  = {req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_wr_data,
                mem_write_length, mem_wr_enable};
        expv = {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL reset_values got=%h want=%h", obs, expv);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid);
        end
    endtask

    typedef struct packed {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    task automatic test_directed();
        vec_t        tbl [11];
        logic [31:0] rd;
        logic        er;
        int          lat, wes, viol;
        tbl = '{
            '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b1, 3'd0, 32'h21,   32'h000000F3, 32'h0,        1'b0},
            '{1'b0, 3'd0, 32'h21,   32'h0,        32'hFFFFFFF3, 1'b0},
            '{1'b0, 3'd4, 32'h21,   32'h0,        32'h000000F3, 1'b0},
            '{1'b1, 3'd1, 32'h40,   32'h00008001, 32'h0,        1'b0},
            '{1'b0, 3'd1, 32'h40,   32'h0,        32'hFFFF8001, 1'b0},
            '{1'b0, 3'd5, 32'h40,   32'h0,        32'h00008001, 1'b0},
            '{1'b1, 3'd2, 32'h42,   32'h11223344, 32'h0,        1'b1},
            '{1'b1, 3'd2, 32'h13E6, 32'h55667788, 32'h0,        1'b1},
            '{1'b0, 3'd3, 32'h10,   32'h0,        32'h0,        1'b1}
        };
        for (int t = 0; t < 11; t++) begin
            do_req(tbl[t].w, tbl[t].f3, tbl[t].a, tbl[t].wd, 0, rd, er, lat, wes, viol);
            total++;
            if (rd !== tbl[t].rd || er !== tbl[t].err) begin
                bad++;
                $display("FAIL directed_%0d_result rdata=%h err=%b want rdata=%h err=%b",
                         t, rd, er, tbl[t].rd, tbl[t].err);
            end
            total++;
            if (lat != 2 || wes != ((tbl[t].w && !tbl[t].err) ? 1 : 0) || viol != 0) begin
                bad++;
                $display("FAIL directed_%0d_protocol lat=%0d we=%0d viol=%0d want lat=2 we=%0d viol=0",
                         t, lat, wes, viol, (tbl[t].w && !tbl[t].err) ? 1 : 0);
            end
            if (tbl[t].w && !tbl[t].err) model_store(tbl[t].f3, tbl[t].a, tbl[t].wd);
        end
        total++;
        if ({dmem[16], dmem[17], dmem[18], dmem[19]} !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL directed_sw_bytes got=%h want=deadbeef",
                     {dmem[16], dmem[17], dmem[18], dmem[19]});
        end
        total++;
        if (dmem[32] !== pattern_byte(32) || dmem[34] !== pattern_byte(34) || dmem[33] !== 8'hF3) begin
            bad++;
            $display("FAIL directed_sb_neighbours got=%h %h %h want=%h f3 %h",
                     dmem[32], dmem[33], dmem[34], pattern_byte(32), pattern_byte(34));
        end
        total++;
        if (count_diffs() != 0) begin
            bad++;
            $display("FAIL directed_memory diffs=%0d want=0", count_diffs());
        end
    endtask

    task automatic test_boundary();
        logic [31:0] addrs [6];
        logic [2:0]  f3s   [6];
        logic [31:0] rd;
        logic        er;
        int          lat, wes, viol;
        addrs = '{32'd5092, 32'd5095, 32'd5096, 32'd5094, 32'hFFFFFFFC, 32'd5093};
        f3s   = '{3'd2,     3'd4,     3'd0,     3'd5,     3'd2,         3'd1};
        for (int t = 0; t < 6; t++) begin
            do_req(1'b0, f3s[t], addrs[t], 32'h0, 0, rd, er, lat, wes, viol);
            total++;
            if (er !== model_err(1'b0, f3s[t], addrs[t]) ||
                rd !== (model_err(1'b0, f3s[t], addrs[t]) ? 32'h0 : model_load(f3s[t], addrs[t]))) begin
                bad++;
                $display("FAIL boundary_%0d rdata=%h err=%b want rdata=%h err=%b", t, rd, er,
                         model_err(1'b0, f3s[t], addrs[t]) ? 32'h0 : model_load(f3s[t], addrs[t]),
                         model_err(1'b0, f3s[t], addrs[t]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat, wes, viol;
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er, lat, wes, viol);
        total++;
        if (rd !== model_load(3'd2, 32'h10) || er !== 1'b0 || lat != 2 || viol != 0) begin
            bad++;
            $display("FAIL backpressure rdata=%h err=%b lat=%0d viol=%0d want rdata=%h err=0 lat=2 viol=0",
                     rd, er, lat, viol, model_load(3'd2, 32'h10));
        end
    endtask

    task automatic test_reset_mid();
        logic [103:0] obs;
        logic [103:0] expv;
        int           n;
        expv = {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0};
        // Reset while the store is in its write cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h80;
        req_wdata = 32'hA5A5A5A5; resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2;
        total++;
        if (mem_wr_enable !== 1'b1) begin
            bad++;
            $display("FAIL reset_access_pre we=%b want=1", mem_wr_enable);
        end
        reset_n = 1'b0;
        #1;
        obs = {req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_wr_data,
               mem_write_length, mem_wr_enable};
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL reset_access_outputs got=%h want=%h", obs, expv);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (dmem[128] !== ref_mem[128] || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_access_after M80=%h req_ready=%b resp_valid=%b want M80=%h 1 0",
                     dmem[128], req_ready, resp_valid, ref_mem[128]);
        end
        // Reset while a response is pending.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        reset_n = 1'b0;
        #1;
        obs = {req_ready, resp_valid, resp_rdata, resp_error, mem_address, mem_wr_data,
               mem_write_length, mem_wr_enable};
        total++;
        if (n >= 10 || obs !== expv) begin
            bad++;
            $display("FAIL reset_resp waited=%0d got=%h want=%h", n, obs, expv);
        end
        @(negedge clk);
        reset_n = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd, exp_rd;
        logic        er, exp_er;
        int          lat, wes, viol, stall, r;
        for (int t = 0; t < 60; t++) begin
            r  = $urandom_range(0, 9);
            if (r == 0)      a = 32'(MEM_BYTES - $urandom_range(0, 6));
            else if (r == 1) a = $urandom;
            else             a = 32'($urandom_range(0, 511));
            w     = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            wd    = $urandom;
            stall = $urandom_range(0, 3);
            exp_er = model_err(w, f3, a);
            exp_rd = (w || exp_er) ? 32'h0 : model_load(f3, a);
            do_req(w, f3, a, wd, stall, rd, er, lat, wes, viol);
            total++;
            if (rd !== exp_rd || er !== exp_er) begin
                bad++;
                $display("FAIL random_%0d_result rdata=%h err=%b want rdata=%h err=%b",
                         t, rd, er, exp_rd, exp_er);
            end
            total++;
            if (lat != 2 || wes != ((w && !exp_er) ? 1 : 0) || viol != 0) begin
                bad++;
                $display("FAIL random_%0d_protocol lat=%0d we=%0d viol=%0d want lat=2 we=%0d viol=0",
                         t, lat, wes, viol, (w && !exp_er) ? 1 : 0);
            end
            if (w && !exp_er) model_store(f3, a, wd);
        end
        total++;
        if (count_diffs() != 0) begin
            bad++;
            $display("FAIL random_memory diffs=%0d want=0", count_diffs());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
